mapper4510_ctx_xfer: RTL
========================

# mapper4510_ctx_xfer

Save/restore sequencer for the user-mode 4510 MAP registers. On hypervisor entry it reads the four user map bytes (A, X, Y, Z) out of the mapper's register-readback mux into a 4-byte shadow. On hypervisor exit it writes them back through the mapper's `hypervisor_load_user_reg` path. It sits in the hypervisor controller between the trap/return logic and the mapper, and waits for the mapper's fast-table refresh to finish before reporting completion.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `save_req` in 1: pulse; starts a SAVE. Sampled only in IDLE.
- `restore_req` in 1: pulse; starts a RESTORE. Sampled only in IDLE.
- `map_active` in 1: CPU is executing MAP (mapper FSM `map`=1). Stalls all transfers.
- `mapper_busy` in 1: mapper fast-table refresh in progress.
- `map_reg_data` in 8: mapper readback byte for the currently selected register. Combinational in the same cycle as `map_reg_sel`.
- `map_reg_sel` out 2: register select; 3=A, 2=X, 1=Y, 0=Z.
- `hv_load_user_reg` out 1: write strobe to mapper.
- `hv_data` out 8: write data to mapper.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: refresh timeout flag. Sticky until the next accepted request.
- `sh_idx` in 2: shadow access index, same encoding as `map_reg_sel`.
- `sh_we` in 1: shadow write enable.
- `sh_wdata` in 8: shadow write data.
- `sh_rdata` out 8: shadow[`sh_idx`], combinational.

## Operation
- States: IDLE, SAVE, RESTORE, SETTLE, WAIT_REFRESH, DONE. A 2-bit `idx` counts down from 3 to 0.
- IDLE:
  - `save_req` → SAVE with idx=3.
  - Else `restore_req` → RESTORE with idx=3.
  - If both are asserted in the same cycle, SAVE wins and the restore is dropped.
  - Accepting either request clears `err`.
- SAVE:
  - `map_reg_sel`=idx.
  - If `map_active`=0: shadow[idx] ← `map_reg_data` at the clock edge, then idx decrements. After idx=0 is captured, go to DONE.
  - If `map_active`=1: no capture; idx holds.
- RESTORE:
  - `map_reg_sel`=idx and `hv_data`=shadow[idx].
  - `hv_load_user_reg` = ~`map_active`, decoded combinationally.
  - idx decrements only on cycles where the strobe was high. Order is A, X, Y, Z. Z goes last because it triggers the mapper refresh.
  - After the Z write, go to SETTLE.
- SETTLE: one cycle, so `mapper_busy` can rise. Then go to WAIT_REFRESH and clear the watchdog.
- WAIT_REFRESH:
  - 6-bit watchdog increments each cycle.
  - `mapper_busy`=0 → DONE.
  - If the watchdog reaches 63 with `mapper_busy` still 1: set `err`, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in SAVE, RESTORE, SETTLE and WAIT_REFRESH; it is 0 in IDLE and DONE.
- Shadow port:
  - `sh_we` writes shadow[`sh_idx`] only when state is IDLE; it is ignored otherwise.
  - Reads are always allowed.
  - A SAVE capture to the same index in the same cycle as an ignored `sh_we`: the capture wins.
- Reset (including mid-sequence):
  - state=IDLE; all shadow bytes 00.
  - `busy`, `done`, `err`, `hv_load_user_reg` = 0; `map_reg_sel`=0; `hv_data`=00.
  - A partially written mapper is not repaired; the mapper's own reset covers it.
- In IDLE and DONE: `map_reg_sel`=0, `hv_data`=00, `hv_load_user_reg`=0.

## Timing
- Request sampled at edge E0 → first SAVE/RESTORE cycle follows E0.
- SAVE with no stalls: 4 busy cycles, then `done` in cycle 5. Each `map_active` cycle adds 1.
- RESTORE with no stalls:
  - 4 write cycles, then SETTLE (1 cycle), then WAIT_REFRESH (N cycles until `mapper_busy` falls, including the first cycle it reads 0), then DONE.
  - With the standard 32-cycle mapper refresh, `done` arrives roughly 38 cycles after E0.
- `map_active` is evaluated per cycle. A stall never drops a byte or writes a byte twice.
- `mapper_busy` is ignored outside WAIT_REFRESH. If it is already 0 on the first WAIT_REFRESH cycle, `done` follows next cycle.
- A `save_req`/`restore_req` arriving while not IDLE is lost; it is not queued.

## Test plan
- Save: mapper holds A=12, X=34, Y=56, Z=78; pulse `save_req` → `map_reg_sel` steps 3,2,1,0 over 4 cycles; `done` in cycle 5; `sh_rdata` at idx 3/2/1/0 = 12/34/56/78.
- Restore: `sh_we` loads A=9A, X=3B, Y=C0, Z=1D; pulse `restore_req` → four strobes with (sel,data) = (3,9A), (2,3B), (1,C0), (0,1D); `busy` held through the 32-cycle `mapper_busy`; single `done`; `err`=0.
- Stall: hold `map_active`=1 for 3 cycles during the X write → no strobe during the stall; X written exactly once after release; total latency +3.
- Timeout: hold `mapper_busy`=1 forever after the Z write → `done` after 63 WAIT_REFRESH cycles with `err`=1; `err` clears on the next `save_req`.
- Collision/reset: assert `save_req` and `restore_req` together → SAVE only, no strobes. In a separate run, assert `reset` mid-RESTORE after the Y write → strobe low the next cycle, shadow reads 00, `busy`=0, no `done`.
- Shadow write while busy: `sh_we` with idx=2, data=FF during SAVE → ignored; shadow[2] holds the captured X.

Source files
------------

// File: rtl/mapper4510_ctx_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : mapper4510_ctx_xfer
//  Purpose  : Save/restore sequencer for the user-mode 4510 MAP registers.
//             SAVE copies A/X/Y/Z from the mapper readback mux into a 4-byte
//             shadow; RESTORE writes them back through the mapper's
//             user-register load strobe, then waits for the fast-table
//             refresh (with a watchdog) before signalling completion.
//  Revision : 1.0  initial release
// ============================================================================
module mapper4510_ctx_xfer (
   input  logic       clk,
   input  logic       reset,
   input  logic       save_req,
   input  logic       restore_req,
   input  logic       map_active,
   input  logic       mapper_busy,
   input  logic [7:0] map_reg_data,
   output logic [1:0] map_reg_sel,
   output logic       hv_load_user_reg,
   output logic [7:0] hv_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic [1:0] sh_idx,
   input  logic       sh_we,
   input  logic [7:0] sh_wdata,
   output logic [7:0] sh_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_SAVE         = 3'd1,
      ST_RESTORE      = 3'd2,
      ST_SETTLE       = 3'd3,
      ST_WAIT_REFRESH = 3'd4,
      ST_DONE         = 3'd5
   } state_t;

   // Watchdog value seen on the last allowed WAIT_REFRESH cycle: the count
   // would reach 63 on this cycle, so the refresh is declared stuck.
   localparam logic [5:0] WDOG_LAST = 6'd62;

   state_t     state, state_next;
   logic [1:0] idx, idx_next;
   logic [5:0] wdog, wdog_next;
   logic       err_next;
   logic       capture;
   logic [7:0] shadow [4];

   // Sequencer state, byte index, watchdog and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         idx   <= 2'd0;
         wdog  <= 6'd0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         wdog  <= wdog_next;
         err   <= err_next;
      end
   end

   // Next-state decode and mapper-facing outputs.
   always_comb begin
      state_next       = state;
      idx_next         = idx;
      wdog_next        = wdog;
      err_next         = err;
      capture          = 1'b0;
      map_reg_sel      = 2'd0;
      hv_data          = 8'h00;
      hv_load_user_reg = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;

      case (state)
         ST_IDLE: begin
            // SAVE has priority; a simultaneous restore is dropped.
            if (save_req) begin
               state_next = ST_SAVE;
               idx_next   = 2'd3;
               err_next   = 1'b0;
            end else if (restore_req) begin
               state_next = ST_RESTORE;
               idx_next   = 2'd3;
               err_next   = 1'b0;
            end
         end

         ST_SAVE: begin
            busy        = 1'b1;
            map_reg_sel = idx;
            // While the CPU runs MAP the readback is not trustworthy: hold.
            if (!map_active) begin
               capture = 1'b1;
               if (idx == 2'd0) state_next = ST_DONE;
               else             idx_next   = idx - 2'd1;
            end
         end

         ST_RESTORE: begin
            busy             = 1'b1;
            map_reg_sel      = idx;
            hv_data          = shadow[idx];
            hv_load_user_reg = ~map_active;
            // Advance only when a strobe actually went out, so a stall
            // neither skips nor repeats a byte. Z (idx 0) goes last since
            // it kicks off the mapper refresh.
            if (!map_active) begin
               if (idx == 2'd0) state_next = ST_SETTLE;
               else             idx_next   = idx - 2'd1;
            end
         end

         ST_SETTLE: begin
            // Gives mapper_busy one cycle to rise after the Z write.
            busy       = 1'b1;
            wdog_next  = 6'd0;
            state_next = ST_WAIT_REFRESH;
         end

         ST_WAIT_REFRESH: begin
            busy      = 1'b1;
            wdog_next = wdog + 6'd1;
            if (!mapper_busy) begin
               state_next = ST_DONE;
            end else if (wdog == WDOG_LAST) begin
               err_next   = 1'b1;
               state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end

         default: state_next = ST_IDLE;
      endcase
   end

   // Shadow storage: SAVE captures, host writes only while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) shadow[i] <= 8'h00;
      end else if (capture) begin
         shadow[idx] <= map_reg_data;
      end else if (state == ST_IDLE && sh_we) begin
         shadow[sh_idx] <= sh_wdata;
      end
   end

   assign sh_rdata = shadow[sh_idx];

endmodule
`default_nettype wire
